// File: rtl/inst_dispatcher.sv
// Instruction dispatcher: turns LD/ST/GEMM/DRAINSYS instructions into SRAM burst and controller traffic.
// Optional busy-cycle counter is enabled by defining DISPATCH_PERF_CNT_EN.
module inst_dispatcher #(
    parameter int OPCODE_WIDTH         = 4,
    parameter int BUF_ID_WIDTH         = 2,
    parameter int MEM_LOC_WIDTH        = 10,
    parameter int LOG2_SRAM_BANK_DEPTH = 10,
    parameter int NUM_ROW              = 8,
    parameter int NUM_COL              = 8,
    parameter int DATA_WIDTH           = 8,
    parameter int ACCU_DATA_WIDTH      = 32,
    parameter int CTRL_WIDTH           = 4,
    parameter int BURST_LEN            = 8,
    parameter logic [OPCODE_WIDTH-1:0] opcode_LD       = 4'b0010,
    parameter logic [OPCODE_WIDTH-1:0] opcode_ST       = 4'b0011,
    parameter logic [OPCODE_WIDTH-1:0] opcode_GEMM     = 4'b0100,
    parameter logic [OPCODE_WIDTH-1:0] opcode_DRAINSYS = 4'b0101
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                inst_valid,
    output logic                                inst_ready,
    input  logic [OPCODE_WIDTH-1:0]             opcode,
    input  logic [BUF_ID_WIDTH-1:0]             buf_id,
    input  logic [MEM_LOC_WIDTH-1:0]            mem_loc,
    output logic                                ext_rd_en,
    output logic [MEM_LOC_WIDTH-1:0]            ext_rd_addr,
    input  logic [NUM_COL*DATA_WIDTH-1:0]       ext_rd_data,
    output logic                                ext_wr_en,
    output logic [MEM_LOC_WIDTH-1:0]            ext_wr_addr,
    output logic [NUM_COL*ACCU_DATA_WIDTH-1:0]  ext_wr_data,
    output logic                                i_top_wr_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_top_wr_addr,
    output logic [NUM_COL*DATA_WIDTH-1:0]       i_top_wr_data,
    output logic                                i_left_wr_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_left_wr_addr,
    output logic [NUM_COL*DATA_WIDTH-1:0]       i_left_wr_data,
    output logic                                i_down_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_down_rd_addr,
    input  logic [NUM_COL*ACCU_DATA_WIDTH-1:0]  o_down_rd_data,
    output logic [CTRL_WIDTH-1:0]               i_ctrl_state,
    input  logic                                ctrl_done,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_top_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_top_sram_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_left_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_left_sram_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_down_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_down_sram_rd_end_addr,
    output logic                                busy,
    output logic                                err_illegal,
    output logic [31:0]                         perf_busy_cycles
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LD    = 3'd1;
    localparam logic [2:0] S_ST    = 3'd2;
    localparam logic [2:0] S_GEMM  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic [BUF_ID_WIDTH-1:0] BUF_TOP  = BUF_ID_WIDTH'(0);
    localparam logic [BUF_ID_WIDTH-1:0] BUF_LEFT = BUF_ID_WIDTH'(1);
    localparam logic [BUF_ID_WIDTH-1:0] BUF_DOWN = BUF_ID_WIDTH'(2);

    localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE  = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] CTRL_GEMM  = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] CTRL_DRAIN = CTRL_WIDTH'(2);

    if (NUM_ROW != NUM_COL || LOG2_SRAM_BANK_DEPTH != MEM_LOC_WIDTH) begin : g_bad_cfg
        $error("inst_dispatcher: NUM_ROW must equal NUM_COL and LOG2_SRAM_BANK_DEPTH must equal MEM_LOC_WIDTH");
    end

    logic [2:0]                      state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [MEM_LOC_WIDTH-1:0]        base_q, base_d;
    logic                            sel_left_q, sel_left_d;
    logic                            err_q, err_d;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] win_start_q, win_start_d;
    logic [LOG2_SRAM_BANK_DEPTH-1:0] win_end_q, win_end_d;

    logic                     accept;
    logic                     rd_phase;
    logic                     wr_phase;
    logic [MEM_LOC_WIDTH-1:0] rd_addr;
    logic [MEM_LOC_WIDTH-1:0] wr_addr;

    assign inst_ready = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign accept     = inst_valid && inst_ready;

    // Burst pipeline: cnt 0..BURST_LEN-1 issue reads, cnt 1..BURST_LEN land writes one cycle later.
    assign rd_phase = (cnt_q < CNT_W'(BURST_LEN));
    assign wr_phase = (cnt_q != '0);
    assign rd_addr  = base_q + MEM_LOC_WIDTH'(cnt_q);
    assign wr_addr  = rd_addr - MEM_LOC_WIDTH'(1);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        sel_left_d  = sel_left_q;
        err_d       = err_q;
        win_start_d = win_start_q;
        win_end_d   = win_end_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    base_d     = mem_loc;
                    sel_left_d = (buf_id == BUF_LEFT);
                    cnt_d      = '0;
                    if (opcode == opcode_LD && (buf_id == BUF_TOP || buf_id == BUF_LEFT)) begin
                        state_d = S_LD;
                    end else if (opcode == opcode_ST && buf_id == BUF_DOWN) begin
                        state_d = S_ST;
                    end else if (opcode == opcode_GEMM) begin
                        state_d     = S_GEMM;
                        win_start_d = LOG2_SRAM_BANK_DEPTH'(mem_loc);
                        win_end_d   = LOG2_SRAM_BANK_DEPTH'(mem_loc + MEM_LOC_WIDTH'(BURST_LEN - 1));
                    end else if (opcode == opcode_DRAINSYS) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_LD, S_ST: begin
                if (cnt_q == CNT_W'(BURST_LEN)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GEMM, S_DRAIN: begin
                if (ctrl_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ext_rd_en      = 1'b0;
        ext_rd_addr    = '0;
        ext_wr_en      = 1'b0;
        ext_wr_addr    = '0;
        ext_wr_data    = '0;
        i_top_wr_en    = 1'b0;
        i_top_wr_addr  = '0;
        i_top_wr_data  = '0;
        i_left_wr_en   = 1'b0;
        i_left_wr_addr = '0;
        i_left_wr_data = '0;
        i_down_rd_en   = 1'b0;
        i_down_rd_addr = '0;
        i_ctrl_state   = CTRL_IDLE;

        case (state_q)
            S_LD: begin
                if (rd_phase) begin
                    ext_rd_en   = 1'b1;
                    ext_rd_addr = rd_addr;
                end
                if (wr_phase && sel_left_q) begin
                    i_left_wr_en   = 1'b1;
                    i_left_wr_addr = LOG2_SRAM_BANK_DEPTH'(wr_addr);
                    i_left_wr_data = ext_rd_data;
                end else if (wr_phase) begin
                    i_top_wr_en   = 1'b1;
                    i_top_wr_addr = LOG2_SRAM_BANK_DEPTH'(wr_addr);
                    i_top_wr_data = ext_rd_data;
                end
            end
            S_ST: begin
                if (rd_phase) begin
                    i_down_rd_en   = 1'b1;
                    i_down_rd_addr = LOG2_SRAM_BANK_DEPTH'(rd_addr);
                end
                if (wr_phase) begin
                    ext_wr_en   = 1'b1;
                    ext_wr_addr = wr_addr;
                    ext_wr_data = o_down_rd_data;
                end
            end
            S_GEMM:  i_ctrl_state = CTRL_GEMM;
            S_DRAIN: i_ctrl_state = CTRL_DRAIN;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            sel_left_q  <= 1'b0;
            err_q       <= 1'b0;
            win_start_q <= '0;
            win_end_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            sel_left_q  <= sel_left_d;
            err_q       <= err_d;
            win_start_q <= win_start_d;
            win_end_q   <= win_end_d;
        end
    end

    assign err_illegal               = err_q;
    assign i_top_sram_rd_start_addr  = win_start_q;
    assign i_top_sram_rd_end_addr    = win_end_q;
    assign i_left_sram_rd_start_addr = win_start_q;
    assign i_left_sram_rd_end_addr   = win_end_q;
    assign i_down_sram_rd_start_addr = win_start_q;
    assign i_down_sram_rd_end_addr   = win_end_q;

`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (busy && perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_busy_cycles = perf_q;
`else
    assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_inst_dispatcher.sv
// Self-checking bench for inst_dispatcher: memory models plus per-channel scoreboards checked at negedge.
// Build with DISPATCH_PERF_CNT_EN defined to also check the busy-cycle counter.
module tb_inst_dispatcher;

    localparam int BL = 8;
    localparam logic [3:0] OP_LD    = 4'b0010;
    localparam logic [3:0] OP_ST    = 4'b0011;
    localparam logic [3:0] OP_GEMM  = 4'b0100;
    localparam logic [3:0] OP_DRAIN = 4'b0101;

    typedef struct packed {
        logic [9:0]   addr;
        logic [255:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inst_valid;
    logic         inst_ready;
    logic [3:0]   opcode;
    logic [1:0]   buf_id;
    logic [9:0]   mem_loc;
    logic         ext_rd_en;
    logic [9:0]   ext_rd_addr;
    logic [63:0]  ext_rd_data;
    logic         ext_wr_en;
    logic [9:0]   ext_wr_addr;
    logic [255:0] ext_wr_data;
    logic         i_top_wr_en, i_left_wr_en, i_down_rd_en;
    logic [9:0]   i_top_wr_addr, i_left_wr_addr, i_down_rd_addr;
    logic [63:0]  i_top_wr_data, i_left_wr_data;
    logic [255:0] o_down_rd_data;
    logic [3:0]   i_ctrl_state;
    logic         ctrl_done;
    logic [9:0]   top_s, top_e, left_s, left_e, down_s, down_e;
    logic         busy, err_illegal;
    logic [31:0]  perf_busy_cycles;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    exp_t       q_top[$], q_left[$], q_extwr[$];
    logic [9:0] q_extrd[$], q_downrd[$];

    inst_dispatcher dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .opcode(opcode), .buf_id(buf_id), .mem_loc(mem_loc),
        .ext_rd_en(ext_rd_en), .ext_rd_addr(ext_rd_addr), .ext_rd_data(ext_rd_data),
        .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .i_top_wr_en(i_top_wr_en), .i_top_wr_addr(i_top_wr_addr), .i_top_wr_data(i_top_wr_data),
        .i_left_wr_en(i_left_wr_en), .i_left_wr_addr(i_left_wr_addr), .i_left_wr_data(i_left_wr_data),
        .i_down_rd_en(i_down_rd_en), .i_down_rd_addr(i_down_rd_addr), .o_down_rd_data(o_down_rd_data),
        .i_ctrl_state(i_ctrl_state), .ctrl_done(ctrl_done),
        .i_top_sram_rd_start_addr(top_s), .i_top_sram_rd_end_addr(top_e),
        .i_left_sram_rd_start_addr(left_s), .i_left_sram_rd_end_addr(left_e),
        .i_down_sram_rd_start_addr(down_s), .i_down_sram_rd_end_addr(down_e),
        .busy(busy), .err_illegal(err_illegal), .perf_busy_cycles(perf_busy_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ext_pat(input logic [9:0] a);
        return {22'h3AB0C1, a, 22'h15F00D, a};
    endfunction

    function automatic logic [255:0] down_pat(input logic [9:0] a);
        logic [255:0] r;
        for (int l = 0; l < 8; l++) r[l*32 +: 32] = {a, 6'(l), 16'hC0DE};
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // External and down SRAM models: one-cycle read latency.
    always @(posedge clk) begin
        if (ext_rd_en) ext_rd_data <= ext_pat(ext_rd_addr);
        if (i_down_rd_en) o_down_rd_data <= down_pat(i_down_rd_addr);
    end

    always @(negedge clk) begin
        exp_t e;
        logic [9:0] a;
        if (!rst_n) busy_cnt = 0;
        else busy_cnt += int'(busy);
        if (ext_rd_en) begin
            if (q_extrd.size() == 0) check("ext_rd_unexpected", ext_rd_en, 1'b0);
            else begin a = q_extrd.pop_front(); check("ext_rd_addr", ext_rd_addr, a); end
        end
        if (i_down_rd_en) begin
            if (q_downrd.size() == 0) check("down_rd_unexpected", i_down_rd_en, 1'b0);
            else begin a = q_downrd.pop_front(); check("down_rd_addr", i_down_rd_addr, a); end
        end
        if (i_top_wr_en) begin
            if (q_top.size() == 0) check("top_wr_unexpected", i_top_wr_en, 1'b0);
            else begin
                e = q_top.pop_front();
                check("top_wr_addr", i_top_wr_addr, e.addr);
                check("top_wr_data", i_top_wr_data, e.data);
            end
        end
        if (i_left_wr_en) begin
            if (q_left.size() == 0) check("left_wr_unexpected", i_left_wr_en, 1'b0);
            else begin
                e = q_left.pop_front();
                check("left_wr_addr", i_left_wr_addr, e.addr);
                check("left_wr_data", i_left_wr_data, e.data);
            end
        end
        if (ext_wr_en) begin
            if (q_extwr.size() == 0) check("ext_wr_unexpected", ext_wr_en, 1'b0);
            else begin
                e = q_extwr.pop_front();
                check("ext_wr_addr", ext_wr_addr, e.addr);
                check("ext_wr_data", ext_wr_data, e.data);
            end
        end
    end

    // Called just after a negedge; returns just after the accepting posedge.
    task automatic send(input logic [3:0] op, input logic [1:0] b, input logic [9:0] loc);
        int n = 0;
        while (!inst_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_ready_timeout", inst_ready, 1'b1);
        opcode = op; buf_id = b; mem_loc = loc; inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        opcode  = 4'($urandom);
        buf_id  = 2'($urandom);
        mem_loc = 10'($urandom);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (!inst_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        #1;
    endtask

    task automatic check_queues_empty(input string tag);
        check({tag, "_q_remaining"},
              q_top.size() + q_left.size() + q_extwr.size() + q_extrd.size() + q_downrd.size(), 0);
    endtask

    task automatic do_ld(input logic [1:0] b, input logic [9:0] loc);
        int n;
        logic [9:0] a;
        for (int i = 0; i < BL; i++) begin
            a = loc + 10'(i);
            q_extrd.push_back(a);
            if (b == 2'd1) q_left.push_back('{addr: a, data: 256'(ext_pat(a))});
            else           q_top.push_back('{addr: a, data: 256'(ext_pat(a))});
        end
        send(OP_LD, b, loc);
        wait_idle(n);
        check("ld_ready_low_cycles", n, BL + 1);
        check_queues_empty("ld");
    endtask

    task automatic do_ctrl(input logic [3:0] op, input logic [9:0] loc, input int cycles,
                           input logic [3:0] exp_state);
        send(op, 2'd0, loc);
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk);
            check("ctrl_state_active", i_ctrl_state, exp_state);
            if (i == cycles) ctrl_done = 1'b1;
        end
        @(posedge clk);
        #1 ctrl_done = 1'b0;
        @(negedge clk);
        check("ctrl_state_after_done", i_ctrl_state, 4'd0);
        check("ctrl_ready_after_done", inst_ready, 1'b1);
        #1;
    endtask

    task automatic do_illegal(input logic [3:0] op, input logic [1:0] b);
        int n;
        send(op, b, 10'd5);
        wait_idle(n);
        check("illegal_ready_low_cycles", n, 1);
        check("illegal_err_set", err_illegal, 1'b1);
        check_queues_empty("illegal");
    endtask

    initial begin
        int n;
        logic [9:0] a;
        rst_n = 1'b0; inst_valid = 1'b0; opcode = '0; buf_id = '0; mem_loc = '0; ctrl_done = 1'b0;
        ext_rd_data = '0; o_down_rd_data = '0;
        repeat (2) @(negedge clk);
        check("rst_inst_ready", inst_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ctrl_state", i_ctrl_state, 4'd0);
        check("rst_err", err_illegal, 1'b0);
        check("rst_windows", {top_s, top_e, left_s, left_e, down_s, down_e}, 60'd0);
        check("rst_perf", perf_busy_cycles, 32'd0);
        #1 rst_n = 1'b1;

        do_ld(2'd0, 10'd16);
        do_ld(2'd1, 10'd1020);

        do_ctrl(OP_GEMM, 10'd64, 20, 4'd1);
        check("gemm_top_start", top_s, 10'd64);
        check("gemm_top_end", top_e, 10'd71);
        check("gemm_left_start", left_s, 10'd64);
        check("gemm_left_end", left_e, 10'd71);
        check("gemm_down_start", down_s, 10'd64);
        check("gemm_down_end", down_e, 10'd71);

        for (int i = 0; i < BL; i++) begin
            a = 10'd128 + 10'(i);
            q_downrd.push_back(a);
            q_extwr.push_back('{addr: a, data: down_pat(a)});
        end
        send(OP_ST, 2'd2, 10'd128);
        wait_idle(n);
        check("st_ready_low_cycles", n, BL + 1);
        check_queues_empty("st");
        check("window_hold_start", down_s, 10'd64);
        check("window_hold_end", top_e, 10'd71);

        do_ctrl(OP_DRAIN, 10'd0, 5, 4'd2);

        ctrl_done = 1'b1;
        @(posedge clk);
        #1 ctrl_done = 1'b0;
        @(negedge clk);
        check("idle_ctrl_done_ignored", busy, 1'b0);
        #1;

        check("err_clear_before_illegal", err_illegal, 1'b0);
        do_illegal(4'hF, 2'd0);
        do_illegal(OP_LD, 2'd2);
        do_illegal(OP_ST, 2'd0);

`ifdef DISPATCH_PERF_CNT_EN
        check("perf_busy_count", perf_busy_cycles, 32'(busy_cnt));
`else
        check("perf_tied_zero", perf_busy_cycles, 32'd0);
`endif

        // Abort an LD with reset sampled at the end of its fourth cycle.
        for (int i = 0; i < 4; i++) q_extrd.push_back(10'd200 + 10'(i));
        for (int i = 0; i < 3; i++) begin
            a = 10'd200 + 10'(i);
            q_top.push_back('{addr: a, data: 256'(ext_pat(a))});
        end
        send(OP_LD, 2'd0, 10'd200);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_strobes", {ext_rd_en, ext_wr_en, i_top_wr_en, i_left_wr_en, i_down_rd_en}, 5'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", inst_ready, 1'b1);
        check("abort_err_cleared", err_illegal, 1'b0);
        check("abort_perf_cleared", perf_busy_cycles, 32'd0);
        check_queues_empty("abort");
        #1 rst_n = 1'b1;

        do_ld(2'd0, 10'd300);
`ifdef DISPATCH_PERF_CNT_EN
        check("perf_after_reset", perf_busy_cycles, 32'(busy_cnt));
`else
        check("perf_tied_zero_end", perf_busy_cycles, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_dispatcher.md
Name: inst_dispatcher

Overview:
- Sits directly downstream of the instruction reader.
- Accepts one decoded instruction (opcode, buf_id, mem_loc) per valid/ready handshake.
- Sequences it into systolic-array controller traffic: burst loads from external memory into top/left SRAM, GEMM/drain commands with address windows, and burst stores from down SRAM to external memory.
- Back-pressures the reader while a multi-cycle instruction is in flight.

Parameters:
OPCODE_WIDTH, 4, opcode field width
BUF_ID_WIDTH, 2, buffer select width (0=top, 1=left, 2=down, 3=reserved)
MEM_LOC_WIDTH, 10, instruction address field width
LOG2_SRAM_BANK_DEPTH, 10, SRAM address width (must equal MEM_LOC_WIDTH)
NUM_ROW, 8, array rows (must equal NUM_COL)
NUM_COL, 8, array columns
DATA_WIDTH, 8, operand width
ACCU_DATA_WIDTH, 32, accumulator width
CTRL_WIDTH, 4, controller state width
BURST_LEN, 8, rows moved per LD/ST; GEMM window length
opcode_LD / opcode_ST / opcode_GEMM / opcode_DRAINSYS, 4'b0010 / 4'b0011 / 4'b0100 / 4'b0101, opcode encodings

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
inst_valid  in  1  instruction present
inst_ready  out  1  dispatcher can accept
opcode  in  OPCODE_WIDTH  instruction opcode
buf_id  in  BUF_ID_WIDTH  target buffer
mem_loc  in  MEM_LOC_WIDTH  base address
ext_rd_en  out  1  external memory read strobe
ext_rd_addr  out  MEM_LOC_WIDTH  external read address
ext_rd_data  in  NUM_COL*DATA_WIDTH  read data, valid 1 cycle after ext_rd_en
ext_wr_en  out  1  external write strobe
ext_wr_addr  out  MEM_LOC_WIDTH  external write address
ext_wr_data  out  NUM_COL*ACCU_DATA_WIDTH  store data
i_top_wr_en / i_left_wr_en  out  1  SRAM write enables
i_top_wr_addr / i_left_wr_addr  out  LOG2_SRAM_BANK_DEPTH  SRAM write addresses
i_top_wr_data / i_left_wr_data  out  NUM_COL*DATA_WIDTH  SRAM write data
i_down_rd_en  out  1  down SRAM read strobe
i_down_rd_addr  out  LOG2_SRAM_BANK_DEPTH  down SRAM read address
o_down_rd_data  in  NUM_COL*ACCU_DATA_WIDTH  down data, valid 1 cycle after i_down_rd_en
i_ctrl_state  out  CTRL_WIDTH  0=IDLE, 1=GEMM, 2=DRAIN
ctrl_done  in  1  one-cycle pulse from controller when GEMM/DRAIN completes
i_top/left/down_sram_rd_start_addr, i_top/left/down_sram_rd_end_addr  out  LOG2_SRAM_BANK_DEPTH each  GEMM address windows
busy  out  1  not in IDLE
err_illegal  out  1  sticky: illegal opcode or buf_id seen
perf_busy_cycles  out  32  busy-cycle count (see Optional Feature)

Behaviour:
- Reset (rst_n low at posedge):
  - FSM goes to IDLE; all enables 0; all addresses, data, windows and i_ctrl_state 0.
  - err_illegal 0; perf counter 0; inst_ready 1 in the cycle after reset.
  - Reset mid-burst aborts with no further strobes.
- Handshake:
  - inst_ready = 1 only in IDLE.
  - Accept when inst_valid && inst_ready at posedge; fields are latched.
  - Work starts the next cycle. Inputs are ignored while not ready.
- FSM: IDLE -> {LD, ST, GEMM, DRAIN} on accept; every work state -> IDLE on completion.
- LD (buf_id 0 or 1):
  - Cycles 1..BURST_LEN: ext_rd_en=1, ext_rd_addr = mem_loc+i (i=0..BURST_LEN-1).
  - Cycles 2..BURST_LEN+1: selected buffer wr_en=1, wr_addr = mem_loc+i, wr_data = ext_rd_data.
  - Returns to IDLE after cycle BURST_LEN+1, so inst_ready is high in cycle BURST_LEN+2.
- ST (buf_id 2): same pipeline shape.
  - i_down_rd_en / i_down_rd_addr for i=0..BURST_LEN-1.
  - One cycle later: ext_wr_en=1, ext_wr_addr = mem_loc+i, ext_wr_data = o_down_rd_data.
- GEMM:
  - Latch all three start = mem_loc and end = mem_loc+BURST_LEN-1.
  - Drive i_ctrl_state=1 from cycle 1 until the cycle ctrl_done is sampled high, then IDLE with i_ctrl_state=0.
- DRAIN: i_ctrl_state=2 until ctrl_done, then IDLE.
- ctrl_done in any state other than GEMM/DRAIN is ignored.
- Address arithmetic is modulo 2^LOG2_SRAM_BANK_DEPTH; wrap is silent (e.g. mem_loc=1020, BURST_LEN=8 writes 1020..1023, 0..3).
- Windows hold their last value until the next GEMM.
- Illegal cases each consume one cycle, set err_illegal, and issue no strobes:
  - Opcode not in {LD, ST, GEMM, DRAINSYS}.
  - LD with buf_id 2/3.
  - ST with buf_id != 2.
- err_illegal clears only on reset.

Optional Feature:
- Macro DISPATCH_PERF_CNT_EN.
- Defined: perf_busy_cycles increments by 1 every cycle busy=1, saturating at 2^32-1, cleared by reset.
- Undefined: counter logic absent; perf_busy_cycles tied to 0.

Test Plan:
- Reset then LD top at mem_loc=16 with ext_rd_data=addr-tagged pattern -> i_top_wr_en high 8 cycles, addrs 16..23, data matching ext rows 16..23; inst_ready low for 9 cycles.
- LD left at mem_loc=1020 -> ext reads and writes at 1020..1023, 0..3; no top writes.
- GEMM mem_loc=64, ctrl_done after 20 cycles -> all windows 64..71, i_ctrl_state=1 for 20 cycles then 0, accept on next cycle.
- ST buf_id=2 at mem_loc=128 -> down reads 128..135, ext_wr_en 8 cycles one cycle later with matching data; DRAINSYS -> i_ctrl_state=2 until ctrl_done.
- Opcode 4'b1111 and LD with buf_id=2 -> err_illegal set, no strobes, inst_ready back after 1 cycle.
- rst_n low at cycle 4 of an LD -> all strobes 0 the next cycle, IDLE, err_illegal 0; with DISPATCH_PERF_CNT_EN, perf_busy_cycles=0 after reset and equals busy cycle count otherwise.
